// File: rtl/frame_receiver.sv
// Captures one fixed-length big-endian byte frame into a 256x16 buffer, read back via a 1-cycle registered port.
// Latency: one byte per clk in, read data one cycle after address; no backpressure, rxd is sampled every cycle.
module frame_receiver #(
  parameter int frame_length = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxd,
  input  logic        frame_begin,
  input  logic        go,
  output logic        busy,
  output logic        frame_complete,
  input  logic [7:0]  read_addr,
  output logic [15:0] read_data
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BEGIN,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [8:0] last_byte = 9'(frame_length - 1);

  state_t      state;
  state_t      state_next;
  logic [8:0]  byte_cnt;
  logic [7:0]  hi_byte;
  logic        take_first;
  logic        take_byte;
  logic        wr_en;
  logic [15:0] mem [256];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    busy           = 1'b0;
    frame_complete = 1'b0;
    take_first     = 1'b0;
    take_byte      = 1'b0;
    case (state)
      IDLE: begin
        if (go) state_next = WAIT_BEGIN;
      end
      WAIT_BEGIN: begin
        busy = 1'b1;
        if (frame_begin) begin
          take_first = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        busy      = 1'b1;
        take_byte = 1'b1;
        if (byte_cnt == last_byte) state_next = DONE;
      end
      DONE: begin
        frame_complete = 1'b1;
        if (go) state_next = WAIT_BEGIN;
      end
      default: state_next = IDLE;
    endcase
  end

  // byte_cnt holds the index of the byte arriving this cycle while capturing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt  <= '0;
      hi_byte   <= '0;
      read_data <= '0;
    end else begin
      read_data <= mem[read_addr];
      if (take_first) begin
        hi_byte  <= rxd;
        byte_cnt <= 9'd1;
      end else if (take_byte) begin
        if (!byte_cnt[0]) hi_byte <= rxd;
        byte_cnt <= byte_cnt + 9'd1;
      end
    end
  end

  assign wr_en = take_byte & byte_cnt[0];

  // Buffer is deliberately not reset so a frame survives a controller reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[byte_cnt[8:1]] <= {hi_byte, rxd};
  end

endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver: a 4-byte and a 512-byte instance share stimulus; reads scored via a queue.
module tb_frame_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxd;
  logic        frame_begin;
  logic        go;
  logic [7:0]  read_addr;
  logic        busy4, fc4, busy512, fc512;
  logic [15:0] rd4, rd512;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp4   [256];
  logic [15:0] exp512 [256];
  logic [15:0] exp_q  [$];

  always #5 clk = ~clk;

  frame_receiver #(.frame_length(4)) dut4 (
    .clk(clk), .rst(rst), .rxd(rxd), .frame_begin(frame_begin), .go(go),
    .busy(busy4), .frame_complete(fc4), .read_addr(read_addr), .read_data(rd4)
  );

  frame_receiver #(.frame_length(512)) dut512 (
    .clk(clk), .rst(rst), .rxd(rxd), .frame_begin(frame_begin), .go(go),
    .busy(busy512), .frame_complete(fc512), .read_addr(read_addr), .read_data(rd512)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic fb);
    rxd         = b;
    frame_begin = fb;
    tick();
    frame_begin = 1'b0;
  endtask

  task automatic rd(input logic sel, input logic [7:0] a);
    read_addr = a;
    exp_q.push_back(sel ? exp512[a] : exp4[a]);
    tick();
    check(sel ? "read512" : "read4", sel ? rd512 : rd4, exp_q.pop_front());
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  initial begin
    logic [7:0] magic [6];
    logic [7:0] prev;
    magic[0] = 8'hF6; magic[1] = 8'hF6; magic[2] = 8'hF6;
    magic[3] = 8'h28; magic[4] = 8'h28; magic[5] = 8'h28;
    prev = 8'h00;
    rst = 1'b0; rxd = 8'h00; frame_begin = 1'b0; go = 1'b0; read_addr = 8'h00;

    // reset state
    tick(); tick();
    check("rst_busy", {15'b0, busy4}, 16'h0);
    check("rst_fc", {15'b0, fc4}, 16'h0);
    check("rst_rdata", rd4, 16'h0);
    check("rst_busy512", {15'b0, busy512}, 16'h0);
    rst = 1'b1;
    tick();

    // basic frame
    pulse_go();
    check("go_busy", {15'b0, busy4}, 16'h1);
    check("go_fc", {15'b0, fc4}, 16'h0);
    for (int i = 0; i < 6; i++) send(magic[i], 1'b0);
    check("magic_busy", {15'b0, busy4}, 16'h1);
    send(8'h00, 1'b1);
    send(8'h01, 1'b0);
    send(8'hAB, 1'b0);
    check("pre_last_fc", {15'b0, fc4}, 16'h0);
    send(8'hCD, 1'b0);
    check("last_fc", {15'b0, fc4}, 16'h1);
    check("last_busy", {15'b0, busy4}, 16'h0);
    exp4[0] = 16'h0001;
    exp4[1] = 16'hABCD;
    rd(1'b0, 8'd0);
    rd(1'b0, 8'd1);

    // no arm: frame_begin from IDLE is ignored
    rst = 1'b0; tick(); rst = 1'b1; tick();
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    check("noarm_busy", {15'b0, busy4}, 16'h0);
    check("noarm_fc", {15'b0, fc4}, 16'h0);
    rd(1'b0, 8'd0);
    rd(1'b0, 8'd1);

    // go and second frame_begin mid-capture are ignored
    pulse_go();
    send(8'hA1, 1'b1);
    go = 1'b1;
    send(8'hB2, 1'b1);
    go = 1'b0;
    send(8'hC3, 1'b0);
    check("ign_busy", {15'b0, busy4}, 16'h1);
    check("ign_fc_early", {15'b0, fc4}, 16'h0);
    send(8'hD4, 1'b0);
    check("ign_fc", {15'b0, fc4}, 16'h1);
    exp4[0] = 16'hA1B2;
    exp4[1] = 16'hC3D4;
    rd(1'b0, 8'd0);
    rd(1'b0, 8'd1);

    // re-arm from DONE, with read-before-write on word 0
    pulse_go();
    check("rearm_fc", {15'b0, fc4}, 16'h0);
    check("rearm_busy", {15'b0, busy4}, 16'h1);
    read_addr = 8'd0;
    send(8'h12, 1'b1);
    exp_q.push_back(exp4[0]);
    send(8'h34, 1'b0);
    check("rbw_old", rd4, exp_q.pop_front());
    exp4[0] = 16'h1234;
    exp_q.push_back(exp4[0]);
    send(8'h56, 1'b0);
    check("rbw_new", rd4, exp_q.pop_front());
    send(8'h78, 1'b0);
    check("rearm_done", {15'b0, fc4}, 16'h1);
    exp4[1] = 16'h5678;
    rd(1'b0, 8'd0);
    rd(1'b0, 8'd1);

    // async reset mid-capture; read_data currently holds word 1
    pulse_go();
    send(8'h9A, 1'b1);
    send(8'hBB, 1'b0);
    exp4[0] = 16'h9ABB;
    check("pre_rst_rdata", rd4, 16'h5678);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", {15'b0, busy4}, 16'h0);
    check("arst_fc", {15'b0, fc4}, 16'h0);
    check("arst_rdata", rd4, 16'h0);
    rst = 1'b1;
    tick();
    pulse_go();
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    check("post_rst_fc", {15'b0, fc4}, 16'h1);
    exp4[0] = 16'h0102;
    exp4[1] = 16'h0304;
    rd(1'b0, 8'd0);
    rd(1'b0, 8'd1);

    // full-length frame on the 512-byte instance
    rst = 1'b0; tick(); rst = 1'b1; tick();
    pulse_go();
    check("full_busy", {15'b0, busy512}, 16'h1);
    for (int i = 0; i < 512; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send(b, i == 0);
      if (i[0]) exp512[i >> 1] = {prev, b};
      prev = b;
      if (i == 510) check("full_fc_early", {15'b0, fc512}, 16'h0);
    end
    check("full_fc", {15'b0, fc512}, 16'h1);
    check("full_busy_end", {15'b0, busy512}, 16'h0);
    rd(1'b1, 8'd0);
    rd(1'b1, 8'd127);
    rd(1'b1, 8'd128);
    rd(1'b1, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
